// File: rtl/bram_pkg.sv
// Shared definitions for the bram_pipe block: controller state encoding,
// write-mode selector values and a small sizing helper.
package bram_pkg;

  // Controller states. CLEAR sweeps zeros through the array; READY serves
  // user reads and writes.
  typedef enum logic {
    CLEAR = 1'b0,
    READY = 1'b1
  } bram_state_e;

  // Values for the WR_MODE parameter.
  localparam int WR_READ_FIRST  = 0;  // same-address read returns the old word
  localparam int WR_WRITE_FIRST = 1;  // same-address read returns the merged new word

  // Number of byte-enable lanes in a data word.
  function automatic int lane_count(input int data_w, input int lane_w);
    return data_w / lane_w;
  endfunction

endpackage

// File: rtl/bram_pipe_oreg.sv
// Optional output register stage: data plus a valid flag. The data register
// only loads on a valid beat, so the output holds between accesses.
module bram_pipe_oreg #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [W-1:0] d_i,
  input  logic         v_i,
  output logic [W-1:0] q_o,
  output logic         v_o
);

  logic [W-1:0] data_q;
  logic         vld_q;

  // Register the beat; valid follows the input every cycle, data only on valid.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      data_q <= '0;
      vld_q  <= 1'b0;
    end else begin
      vld_q <= v_i;
      if (v_i) begin
        data_q <= d_i;
      end
    end
  end

  assign q_o = data_q;
  assign v_o = vld_q;

endmodule

// File: rtl/bram_pipe.sv
// Simple dual-port block RAM with per-lane write enables, write-port
// read-back, selectable read-first/write-first collision behaviour, an
// optional output register stage and a self-clearing controller that sweeps
// zeros through the array after reset or on request.
module bram_pipe
  import bram_pkg::*;
#(
  parameter int D_SIZE     = 64,
  parameter int Q_DEPTH    = 8,
  parameter int LANE_W     = 8,
  parameter int OUT_REG    = 0,
  parameter int WR_MODE    = 0,
  parameter int CLR_ON_RST = 1,
  localparam int LANES     = lane_count(D_SIZE, LANE_W)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               wr_en,
  input  logic [LANES-1:0]   wr_be,
  input  logic [Q_DEPTH-1:0] wr_addr,
  input  logic [D_SIZE-1:0]  wr_din,
  output logic [D_SIZE-1:0]  wr_dout,
  input  logic               rd_en,
  input  logic [Q_DEPTH-1:0] rd_addr,
  output logic [D_SIZE-1:0]  rd_dout,
  output logic               rd_valid,
  input  logic               clr,
  output logic               busy
);

  localparam int Q_SIZE = 1 << Q_DEPTH;

  // State entered on reset: sweep the array only when asked to.
  localparam bram_state_e RST_STATE = (CLR_ON_RST != 0) ? CLEAR : READY;

  // ------------------------------------------------------------------
  // Controller
  // ------------------------------------------------------------------
  bram_state_e        state_q, state_d;
  logic [Q_DEPTH-1:0] cnt_q, cnt_d;
  logic               busy_w;

  assign busy_w = (state_q == CLEAR);
  assign busy   = busy_w;

  // Controller state and clear-address counter.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= RST_STATE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Next state: the counter is exactly Q_DEPTH wide, so the last address is
  // all-ones and the sweep ends on the edge that writes it.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      CLEAR: begin
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == '1) begin
          state_d = READY;
          cnt_d   = '0;
        end
      end
      READY: begin
        if (clr) begin
          state_d = CLEAR;
          cnt_d   = '0;
        end
      end
      default: begin
        state_d = RST_STATE;
        cnt_d   = '0;
      end
    endcase
  end

  // ------------------------------------------------------------------
  // Access qualification
  // ------------------------------------------------------------------
  // User accesses are dropped entirely while the sweep owns the array.
  logic rd_acc;
  logic wr_acc;

  assign rd_acc = rd_en & ~busy_w;
  assign wr_acc = wr_en & ~busy_w;

  // ------------------------------------------------------------------
  // Memory array (no reset, so it maps onto block RAM)
  // ------------------------------------------------------------------
  logic [D_SIZE-1:0]  mem [Q_SIZE];

  logic [Q_DEPTH-1:0] mw_addr;
  logic [LANES-1:0]   mw_be;
  logic [D_SIZE-1:0]  mw_din;

  // The single write port is shared between the clear sweep and user writes.
  always_comb begin
    mw_addr = wr_addr;
    mw_be   = '0;
    mw_din  = wr_din;
    if (busy_w) begin
      mw_addr = cnt_q;
      mw_be   = '1;
      mw_din  = '0;
    end else if (wr_acc) begin
      mw_be   = wr_be;
    end
  end

  // Per-lane write into the array.
  always_ff @(posedge clk) begin
    for (int l = 0; l < LANES; l++) begin
      if (mw_be[l]) begin
        mem[mw_addr][l*LANE_W +: LANE_W] <= mw_din[l*LANE_W +: LANE_W];
      end
    end
  end

  // ------------------------------------------------------------------
  // Read data selection
  // ------------------------------------------------------------------
  logic [D_SIZE-1:0] rd_old;     // stored word at the read address
  logic [D_SIZE-1:0] wr_old;     // stored word at the write address
  logic [D_SIZE-1:0] wr_merged;  // stored word with the enabled lanes replaced
  logic [D_SIZE-1:0] rd_fwd;     // read word after same-edge write forwarding
  logic [D_SIZE-1:0] wr_word;    // word returned on the write port
  logic              fwd_en;

  assign rd_old = mem[rd_addr];
  assign wr_old = mem[wr_addr];

  // Forward new write data to a same-address read only in write-first mode;
  // read-first simply sees the pre-write contents of the array.
  assign fwd_en = (WR_MODE == WR_WRITE_FIRST) && wr_acc && (wr_addr == rd_addr);

  genvar gi;
  generate
    for (gi = 0; gi < LANES; gi++) begin : g_lane
      localparam int LO = gi * LANE_W;
      assign wr_merged[LO +: LANE_W] = wr_be[gi] ? wr_din[LO +: LANE_W]
                                                 : wr_old[LO +: LANE_W];
      assign rd_fwd[LO +: LANE_W]    = (fwd_en && wr_be[gi]) ? wr_din[LO +: LANE_W]
                                                             : rd_old[LO +: LANE_W];
    end
  endgenerate

  assign wr_word = (WR_MODE == WR_WRITE_FIRST) ? wr_merged : wr_old;

  // ------------------------------------------------------------------
  // First pipeline stage (registered read)
  // ------------------------------------------------------------------
  logic [D_SIZE-1:0] rd_q;
  logic              rd_vld_q;
  logic [D_SIZE-1:0] wr_q;
  logic              wr_vld_q;

  // Capture read and read-back words; data holds when no access is accepted.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_q     <= '0;
      rd_vld_q <= 1'b0;
      wr_q     <= '0;
      wr_vld_q <= 1'b0;
    end else begin
      rd_vld_q <= rd_acc;
      wr_vld_q <= wr_acc;
      if (rd_acc) begin
        rd_q <= rd_fwd;
      end
      if (wr_acc) begin
        wr_q <= wr_word;
      end
    end
  end

  // ------------------------------------------------------------------
  // Optional output register stage
  // ------------------------------------------------------------------
  generate
    if (OUT_REG != 0) begin : g_oreg
      logic wr_vld_unused;

      bram_pipe_oreg #(
        .W (D_SIZE)
      ) u_rd_oreg (
        .clk (clk),
        .rst (rst),
        .d_i (rd_q),
        .v_i (rd_vld_q),
        .q_o (rd_dout),
        .v_o (rd_valid)
      );

      bram_pipe_oreg #(
        .W (D_SIZE)
      ) u_wr_oreg (
        .clk (clk),
        .rst (rst),
        .d_i (wr_q),
        .v_i (wr_vld_q),
        .q_o (wr_dout),
        .v_o (wr_vld_unused)
      );
    end else begin : g_no_oreg
      logic unused_wr_vld;

      assign rd_dout       = rd_q;
      assign rd_valid      = rd_vld_q;
      assign wr_dout       = wr_q;
      assign unused_wr_vld = wr_vld_q;
    end
  endgenerate

endmodule

// File: tb/tb_bram_pipe.sv
// Directed bench for bram_pipe: two instances share the stimulus,
// A = (OUT_REG=0, WR_MODE=0) and B = (OUT_REG=1, WR_MODE=1).
module tb_bram_pipe;

  localparam int D  = 16;
  localparam int QD = 4;

  logic          clk     = 1'b0;
  logic          rst     = 1'b1;
  logic          wr_en   = 1'b0;
  logic [1:0]    wr_be   = '0;
  logic [QD-1:0] wr_addr = '0;
  logic [D-1:0]  wr_din  = '0;
  logic          rd_en   = 1'b0;
  logic [QD-1:0] rd_addr = '0;
  logic          clr     = 1'b0;

  logic [D-1:0]  wr_dout_a, rd_dout_a, wr_dout_b, rd_dout_b;
  logic          rd_valid_a, busy_a, rd_valid_b, busy_b;

  int n_chk  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  bram_pipe #(
    .D_SIZE(D), .Q_DEPTH(QD), .LANE_W(8), .OUT_REG(0), .WR_MODE(0), .CLR_ON_RST(1)
  ) dut_a (
    .clk(clk), .rst(rst), .wr_en(wr_en), .wr_be(wr_be), .wr_addr(wr_addr),
    .wr_din(wr_din), .wr_dout(wr_dout_a), .rd_en(rd_en), .rd_addr(rd_addr),
    .rd_dout(rd_dout_a), .rd_valid(rd_valid_a), .clr(clr), .busy(busy_a)
  );

  bram_pipe #(
    .D_SIZE(D), .Q_DEPTH(QD), .LANE_W(8), .OUT_REG(1), .WR_MODE(1), .CLR_ON_RST(1)
  ) dut_b (
    .clk(clk), .rst(rst), .wr_en(wr_en), .wr_be(wr_be), .wr_addr(wr_addr),
    .wr_din(wr_din), .wr_dout(wr_dout_b), .rd_en(rd_en), .rd_addr(rd_addr),
    .rd_dout(rd_dout_b), .rd_valid(rd_valid_b), .clr(clr), .busy(busy_b)
  );

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Count cycles with busy high on each instance, bounded.
  task automatic count_busy(output int na, output int nb);
    int n;
    n  = 0;
    na = 0;
    nb = 0;
    while ((busy_a || busy_b) && n < 40) begin
      if (busy_a) na++;
      if (busy_b) nb++;
      tick();
      n++;
    end
  endtask

  // Read one address; A must answer after 1 edge, B after 2.
  task automatic rd_chk(input logic [QD-1:0] addr, input logic [D-1:0] exp_a,
                        input logic [D-1:0] exp_b, input string tag);
    rd_en   = 1'b1;
    rd_addr = addr;
    tick();
    rd_en = 1'b0;
    check({tag, "/a_valid"}, rd_valid_a, 1);
    check({tag, "/a_dout"}, rd_dout_a, exp_a);
    check({tag, "/b_early"}, rd_valid_b, 0);
    tick();
    check({tag, "/a_valid_drop"}, rd_valid_a, 0);
    check({tag, "/a_hold"}, rd_dout_a, exp_a);
    check({tag, "/b_valid"}, rd_valid_b, 1);
    check({tag, "/b_dout"}, rd_dout_b, exp_b);
    $display("read  addr %0d : a=0x%04h b=0x%04h", addr, rd_dout_a, rd_dout_b);
  endtask

  // Write one word; check the write-port read-back of both instances.
  task automatic wr_chk(input logic [QD-1:0] addr, input logic [D-1:0] din, input logic [1:0] be,
                        input logic [D-1:0] exp_a, input logic [D-1:0] exp_b, input string tag);
    wr_en   = 1'b1;
    wr_addr = addr;
    wr_din  = din;
    wr_be   = be;
    tick();
    wr_en = 1'b0;
    check({tag, "/a_wr_dout"}, wr_dout_a, exp_a);
    tick();
    check({tag, "/b_wr_dout"}, wr_dout_b, exp_b);
    $display("write addr %0d din=0x%04h be=%b : a=0x%04h b=0x%04h", addr, din, be, wr_dout_a, wr_dout_b);
  endtask

  // Same-edge write and read to one address.
  task automatic col_chk(input logic [QD-1:0] addr, input logic [D-1:0] din, input logic [1:0] be,
                         input logic [D-1:0] exp_a, input logic [D-1:0] exp_b, input string tag);
    wr_en   = 1'b1;
    wr_addr = addr;
    wr_din  = din;
    wr_be   = be;
    rd_en   = 1'b1;
    rd_addr = addr;
    tick();
    wr_en = 1'b0;
    rd_en = 1'b0;
    check({tag, "/a_valid"}, rd_valid_a, 1);
    check({tag, "/a_dout"}, rd_dout_a, exp_a);
    tick();
    check({tag, "/b_valid"}, rd_valid_b, 1);
    check({tag, "/b_dout"}, rd_dout_b, exp_b);
    $display("coll  addr %0d din=0x%04h be=%b : a=0x%04h b=0x%04h", addr, din, be, rd_dout_a, rd_dout_b);
  endtask

  initial begin
    int na, nb, n, va, vb;
    logic [D-1:0] da, db;

    // Reset state.
    repeat (3) tick();
    check("rst/busy_a", busy_a, 1);
    check("rst/busy_b", busy_b, 1);
    check("rst/rd_valid_a", rd_valid_a, 0);
    check("rst/rd_valid_b", rd_valid_b, 0);
    check("rst/rd_dout_a", rd_dout_a, 0);
    check("rst/rd_dout_b", rd_dout_b, 0);
    check("rst/wr_dout_a", wr_dout_a, 0);
    check("rst/wr_dout_b", wr_dout_b, 0);
    rst = 1'b0;

    // Initial sweep: exactly 16 busy cycles, then everything reads zero.
    count_busy(na, nb);
    check("init_clear/busy_cycles_a", na, 16);
    check("init_clear/busy_cycles_b", nb, 16);
    $display("clear after reset : busy a=%0d b=%0d cycles", na, nb);
    for (int i = 0; i < 16; i++) begin
      rd_chk(i[QD-1:0], 16'h0000, 16'h0000, $sformatf("zero%0d", i));
    end

    // Lane-masked writes.
    wr_chk(4'd3, 16'hA5A5, 2'b11, 16'h0000, 16'hA5A5, "wr3_full");
    wr_chk(4'd3, 16'h1234, 2'b01, 16'hA5A5, 16'hA534, "wr3_lane0");
    rd_chk(4'd3, 16'hA534, 16'hA534, "rd3");

    // Read/write collisions.
    wr_chk(4'd5, 16'h1111, 2'b11, 16'h0000, 16'h1111, "wr5");
    col_chk(4'd5, 16'h2222, 2'b11, 16'h1111, 16'h2222, "coll_full");
    col_chk(4'd5, 16'h3344, 2'b10, 16'h2222, 16'h3322, "coll_lane1");
    rd_chk(4'd5, 16'h3322, 16'h3322, "rd5");

    // Clear request with a read held on; writes during busy must be lost and
    // a second clr inside the sweep must not restart it.
    rd_en   = 1'b1;
    rd_addr = 4'd3;
    clr     = 1'b1;
    tick();
    clr     = 1'b0;
    wr_en   = 1'b1;
    wr_addr = 4'd7;
    wr_din  = 16'hBEEF;
    wr_be   = 2'b11;
    n  = 0;
    na = 0;
    nb = 0;
    va = 0;
    vb = 0;
    da = '0;
    db = '0;
    while ((busy_a || busy_b) && n < 40) begin
      if (busy_a) na++;
      if (busy_b) nb++;
      if (rd_valid_a) begin va++; da = rd_dout_a; end
      if (rd_valid_b) begin vb++; db = rd_dout_b; end
      clr = (n == 5);
      tick();
      n++;
    end
    rd_en = 1'b0;
    wr_en = 1'b0;
    clr   = 1'b0;
    check("clr/busy_cycles_a", na, 16);
    check("clr/busy_cycles_b", nb, 16);
    check("clr/inflight_valid_a", va, 1);
    check("clr/inflight_valid_b", vb, 1);
    check("clr/inflight_dout_a", da, 16'hA534);
    check("clr/inflight_dout_b", db, 16'hA534);
    $display("clear on request : busy a=%0d b=%0d valid a=%0d b=%0d", na, nb, va, vb);
    rd_chk(4'd3, 16'h0000, 16'h0000, "post_clr3");
    rd_chk(4'd7, 16'h0000, 16'h0000, "post_clr7_lost_wr");
    rd_chk(4'd5, 16'h0000, 16'h0000, "post_clr5");

    // Reset in the middle of a sweep.
    wr_chk(4'd9, 16'h5A5A, 2'b11, 16'h0000, 16'h5A5A, "wr9_first");
    wr_chk(4'd9, 16'h5A5A, 2'b11, 16'h5A5A, 16'h5A5A, "wr9_again");
    rd_chk(4'd9, 16'h5A5A, 16'h5A5A, "rd9");
    clr = 1'b1;
    tick();
    clr = 1'b0;
    repeat (7) tick();
    check("midclr/busy_a", busy_a, 1);
    rst = 1'b1;
    #1;
    check("midclr_rst/rd_dout_a", rd_dout_a, 0);
    check("midclr_rst/rd_dout_b", rd_dout_b, 0);
    check("midclr_rst/wr_dout_a", wr_dout_a, 0);
    check("midclr_rst/wr_dout_b", wr_dout_b, 0);
    check("midclr_rst/rd_valid_a", rd_valid_a, 0);
    check("midclr_rst/rd_valid_b", rd_valid_b, 0);
    check("midclr_rst/busy_a", busy_a, 1);
    check("midclr_rst/busy_b", busy_b, 1);
    $display("reset mid-clear : outputs a=0x%04h b=0x%04h", rd_dout_a, rd_dout_b);
    tick();
    tick();
    rst = 1'b0;
    count_busy(na, nb);
    check("midclr_rst/busy_cycles_a", na, 16);
    check("midclr_rst/busy_cycles_b", nb, 16);
    $display("clear after mid-clear reset : busy a=%0d b=%0d cycles", na, nb);
    rd_chk(4'd9, 16'h0000, 16'h0000, "post_rst9");
    rd_chk(4'd15, 16'h0000, 16'h0000, "post_rst15");

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
